// File: rtl/timer_ctrl.sv
// -----------------------------------------------------------------------------
// timer_ctrl
//   Front-panel controller for the countdown counter of the 03_timer design.
//   Turns debounced button levels into presses (rising edges), edits a
//   two-digit BCD minute setpoint with an optional +30 s offset, and sequences
//   the counter through IDLE / RUN / PAUSE / ALARM. On expiry it holds the
//   counter at 00:00 and drives alarm plus a square-wave beep.
//
// Parameters
//   DEFAULT_HI, DEFAULT_LO  setpoint digits after reset (BCD)
//   ALARM_CYCLES            cycles spent in ALARM before returning to IDLE
//   BEEP_DIV                cycles per beep half-period
//   HOLD_CYCLES             hold time before auto-repeat (auto-repeat build only)
//   REPEAT_CYCLES           auto-repeat step period   (auto-repeat build only)
//
// Configuration macro
//   TIMER_CTRL_AUTOREPEAT_EN  defined: holding up or down alone repeats steps.
//                             undefined: exactly one step per press.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   btn_start/clear/up/down/half   debounced button levels
//   cnt_min_hi/min_lo/sec_hi/sec_lo  counter digit feedback
//   cnt_enabled, cnt_paused  counter control (enabled=0 reloads the setpoint)
//   set_hi, set_lo           setpoint minutes, BCD
//   set_seconds              +30 s offset flag
//   alarm, beep              expiry indication
//   state                    IDLE=0 RUN=1 PAUSE=2 ALARM=3
// -----------------------------------------------------------------------------
module timer_ctrl #(
   parameter logic [3:0]  DEFAULT_HI    = 4'd0,
   parameter logic [3:0]  DEFAULT_LO    = 4'd5,
   parameter int unsigned ALARM_CYCLES  = 2**24,
   parameter int unsigned BEEP_DIV      = 2**12,
   parameter int unsigned HOLD_CYCLES   = 2**22,
   parameter int unsigned REPEAT_CYCLES = 2**20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_start,
   input  logic       btn_clear,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_half,
   input  logic [3:0] cnt_min_hi,
   input  logic [3:0] cnt_min_lo,
   input  logic [2:0] cnt_sec_hi,
   input  logic [3:0] cnt_sec_lo,
   output logic       cnt_enabled,
   output logic       cnt_paused,
   output logic [3:0] set_hi,
   output logic [3:0] set_lo,
   output logic       set_seconds,
   output logic       alarm,
   output logic       beep,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_ALARM = 2'd3
   } state_t;

   localparam int unsigned AW = $clog2(ALARM_CYCLES + 1);
   localparam int unsigned BW = $clog2(BEEP_DIV + 1);

   state_t        state_q;
   logic [4:0]    btn_prev_q;      // {half, down, up, clear, start}
   logic [3:0]    set_hi_q, set_lo_q;
   logic          set_seconds_q;
   logic          cnt_enabled_q, cnt_paused_q, alarm_q, beep_q;
   logic [AW-1:0] alarm_cnt_q;
   logic [BW-1:0] beep_cnt_q;

   logic [3:0]    set_hi_d, set_lo_d;
   logic          set_seconds_d;

   // Press detection: a press is a level that is high now but was low last cycle.
   logic [4:0] btn_now, btn_press;
   logic       start_press, clear_press, up_press, down_press, half_press;

   assign btn_now     = {btn_half, btn_down, btn_up, btn_clear, btn_start};
   assign btn_press   = btn_now & ~btn_prev_q;
   assign start_press = btn_press[0];
   assign clear_press = btn_press[1];
   assign up_press    = btn_press[2];
   assign down_press  = btn_press[3];
   assign half_press  = btn_press[4];

   logic setpoint_nz, cnt_zero;
   assign setpoint_nz = (set_hi_q != 4'd0) || (set_lo_q != 4'd0) || set_seconds_q;
   assign cnt_zero    = (cnt_min_hi == 4'd0) && (cnt_min_lo == 4'd0) &&
                        (cnt_sec_hi == 3'd0) && (cnt_sec_lo == 4'd0);

   // Step events: a press, plus (auto-repeat build) repeat strobes while held.
   logic up_ev, down_ev;

`ifdef TIMER_CTRL_AUTOREPEAT_EN
   localparam int unsigned HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int unsigned HW   = $clog2(HMAX + 1);

   logic [HW-1:0] hold_cnt_q;
   logic          repeating_q;
   logic          hold_active, rep_fire;

   // Counting only while exactly one of up/down is held in IDLE; the press
   // cycle itself restarts the count so the first repeat lands HOLD_CYCLES
   // after the press.
   assign hold_active = (state_q == ST_IDLE) && (btn_up ^ btn_down) &&
                        !up_press && !down_press;
   assign rep_fire    = hold_active &&
                        (hold_cnt_q == (repeating_q ? HW'(REPEAT_CYCLES - 1)
                                                    : HW'(HOLD_CYCLES - 1)));

   always_ff @(posedge clk) begin
      if (rst || !hold_active) begin
         hold_cnt_q  <= '0;
         repeating_q <= 1'b0;
      end else if (rep_fire) begin
         hold_cnt_q  <= '0;
         repeating_q <= 1'b1;
      end else begin
         hold_cnt_q  <= hold_cnt_q + HW'(1);
      end
   end

   assign up_ev   = up_press   || (rep_fire && btn_up);
   assign down_ev = down_press || (rep_fire && btn_down);
`else
   logic unused_repeat_params;
   assign unused_repeat_params = |{HOLD_CYCLES, REPEAT_CYCLES};

   assign up_ev   = up_press;
   assign down_ev = down_press;
`endif

   // Setpoint edit applied in IDLE. Clear wins over every edit; up and down
   // together cancel.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      set_hi_d      = set_hi_q;
      set_lo_d      = set_lo_q;
      set_seconds_d = set_seconds_q;
      if (clear_press) begin
         set_hi_d      = 4'd0;
         set_lo_d      = 4'd0;
         set_seconds_d = 1'b0;
      end else begin
         if (up_ev && !down_ev) begin
            if (set_lo_q == 4'd9) begin
               set_lo_d = 4'd0;
               set_hi_d = (set_hi_q == 4'd9) ? 4'd0 : set_hi_q + 4'd1;
            end else begin
               set_lo_d = set_lo_q + 4'd1;
            end
         end else if (down_ev && !up_ev) begin
            if (set_lo_q == 4'd0) begin
               set_lo_d = 4'd9;
               set_hi_d = (set_hi_q == 4'd0) ? 4'd9 : set_hi_q - 4'd1;
            end else begin
               set_lo_d = set_lo_q - 4'd1;
            end
         end
         if (half_press) set_seconds_d = !set_seconds_q;
      end
   end

   // Main FSM with registered outputs.
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments only, so every
      // register here sees the pre-edge values of the others.
      if (rst) begin
         state_q       <= ST_IDLE;
         btn_prev_q    <= '1;      // a button held through reset fires no press
         set_hi_q      <= DEFAULT_HI;
         set_lo_q      <= DEFAULT_LO;
         set_seconds_q <= 1'b0;
         cnt_enabled_q <= 1'b0;
         cnt_paused_q  <= 1'b0;
         alarm_q       <= 1'b0;
         beep_q        <= 1'b0;
         alarm_cnt_q   <= '0;
         beep_cnt_q    <= '0;
      end else begin
         btn_prev_q <= btn_now;
         case (state_q)
            ST_IDLE: begin
               set_hi_q      <= set_hi_d;
               set_lo_q      <= set_lo_d;
               set_seconds_q <= set_seconds_d;
               // Start is judged against the setpoint before this cycle's edit.
               if (!clear_press && start_press && setpoint_nz) begin
                  state_q       <= ST_RUN;
                  cnt_enabled_q <= 1'b1;
                  cnt_paused_q  <= 1'b0;
               end
            end
            ST_RUN: begin
               if (clear_press) begin
                  state_q       <= ST_IDLE;
                  cnt_enabled_q <= 1'b0;
                  cnt_paused_q  <= 1'b0;
               end else if (cnt_zero) begin
                  // Pause on the same edge so the counter holds at 00:00.
                  state_q      <= ST_ALARM;
                  cnt_paused_q <= 1'b1;
                  alarm_q      <= 1'b1;
                  beep_q       <= 1'b1;
                  alarm_cnt_q  <= '0;
                  beep_cnt_q   <= '0;
               end else if (start_press) begin
                  state_q      <= ST_PAUSE;
                  cnt_paused_q <= 1'b1;
               end
            end
            ST_PAUSE: begin
               if (clear_press) begin
                  state_q       <= ST_IDLE;
                  cnt_enabled_q <= 1'b0;
                  cnt_paused_q  <= 1'b0;
               end else if (start_press) begin
                  state_q      <= ST_RUN;
                  cnt_paused_q <= 1'b0;
               end
            end
            default: begin  // ST_ALARM
               if (clear_press || start_press ||
                   alarm_cnt_q == AW'(ALARM_CYCLES - 1)) begin
                  state_q       <= ST_IDLE;
                  cnt_enabled_q <= 1'b0;
                  cnt_paused_q  <= 1'b0;
                  alarm_q       <= 1'b0;
                  beep_q        <= 1'b0;
               end else begin
                  alarm_cnt_q <= alarm_cnt_q + AW'(1);
                  if (beep_cnt_q == BW'(BEEP_DIV - 1)) begin
                     beep_cnt_q <= '0;
                     beep_q     <= !beep_q;
                  end else begin
                     beep_cnt_q <= beep_cnt_q + BW'(1);
                  end
               end
            end
         endcase
      end
   end

   assign state       = state_q;
   assign cnt_enabled = cnt_enabled_q;
   assign cnt_paused  = cnt_paused_q;
   assign set_hi      = set_hi_q;
   assign set_lo      = set_lo_q;
   assign set_seconds = set_seconds_q;
   assign alarm       = alarm_q;
   assign beep        = beep_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_timer_ctrl
//   Directed scenarios for timer_ctrl followed by a randomized run checked
//   against a behavioural model that keeps the setpoint as an integer minute
//   count (0..99) and derives beep from elapsed ALARM time.
// -----------------------------------------------------------------------------
module tb_timer_ctrl;

   localparam int ALARM_N = 40;
   localparam int BEEP_N  = 4;
   localparam int HOLD_N  = 20;
   localparam int REP_N   = 8;

   // Button vectors packed as {half, down, up, clear, start}.
   localparam logic [4:0] B_START = 5'b00001;
   localparam logic [4:0] B_CLEAR = 5'b00010;
   localparam logic [4:0] B_UP    = 5'b00100;
   localparam logic [4:0] B_DOWN  = 5'b01000;
   localparam logic [4:0] B_HALF  = 5'b10000;

   // Status bundle {state, enabled, paused, alarm, beep}.
   localparam logic [5:0] S_IDLE   = 6'b00_0000;
   localparam logic [5:0] S_RUN    = 6'b01_1000;
   localparam logic [5:0] S_PAUSE  = 6'b10_1100;
   localparam logic [5:0] S_ALARM1 = 6'b11_1111;
   localparam logic [5:0] S_ALARM0 = 6'b11_1110;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_start, btn_clear, btn_up, btn_down, btn_half;
   logic [3:0] cnt_min_hi, cnt_min_lo, cnt_sec_lo;
   logic [2:0] cnt_sec_hi;
   logic       cnt_enabled, cnt_paused, set_seconds, alarm, beep;
   logic [3:0] set_hi, set_lo;
   logic [1:0] state;

   logic [5:0] status;
   logic [8:0] setpt;
   assign status = {state, cnt_enabled, cnt_paused, alarm, beep};
   assign setpt  = {set_seconds, set_hi, set_lo};

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   timer_ctrl #(
      .DEFAULT_HI   (4'd0),
      .DEFAULT_LO   (4'd5),
      .ALARM_CYCLES (ALARM_N),
      .BEEP_DIV     (BEEP_N),
      .HOLD_CYCLES  (HOLD_N),
      .REPEAT_CYCLES(REP_N)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_start  (btn_start),
      .btn_clear  (btn_clear),
      .btn_up     (btn_up),
      .btn_down   (btn_down),
      .btn_half   (btn_half),
      .cnt_min_hi (cnt_min_hi),
      .cnt_min_lo (cnt_min_lo),
      .cnt_sec_hi (cnt_sec_hi),
      .cnt_sec_lo (cnt_sec_lo),
      .cnt_enabled(cnt_enabled),
      .cnt_paused (cnt_paused),
      .set_hi     (set_hi),
      .set_lo     (set_lo),
      .set_seconds(set_seconds),
      .alarm      (alarm),
      .beep       (beep),
      .state      (state)
   );

   // ---------------------------------------------------------------- helpers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_btns(input logic [4:0] lv);
      btn_start = lv[0];
      btn_clear = lv[1];
      btn_up    = lv[2];
      btn_down  = lv[3];
      btn_half  = lv[4];
   endtask

   task automatic set_digits(input bit zero);
      cnt_min_hi = 4'd0;
      cnt_min_lo = zero ? 4'd0 : 4'd5;
      cnt_sec_hi = zero ? 3'd0 : 3'd3;
      cnt_sec_lo = zero ? 4'd0 : 4'd7;
   endtask

   task automatic press(input logic [4:0] lv, input int n = 1);
      for (int i = 0; i < n; i++) begin
         set_btns(lv);
         tick();
         set_btns(5'b0);
         tick();
      end
   endtask

   // ------------------------------------------------------------------ model
   int         m_state, m_min, m_t, m_hold;
   bit         m_sec;
   logic [4:0] m_prev;

   task automatic model_reset();
      m_state = 0;
      m_min   = 5;
      m_sec   = 1'b0;
      m_t     = 0;
      m_hold  = 0;
      m_prev  = '1;
   endtask

   task automatic model_step(input logic [4:0] lv, input bit zero);
      logic [4:0] pr;
      bit up_ev, dn_ev, nz;
      pr     = lv & ~m_prev;
      m_prev = lv;
      up_ev  = pr[2];
      dn_ev  = pr[3];
`ifdef TIMER_CTRL_AUTOREPEAT_EN
      if (m_state == 0 && (lv[2] != lv[3]) && !pr[2] && !pr[3]) m_hold++;
      else m_hold = 0;
      if (m_hold >= HOLD_N && (m_hold - HOLD_N) % REP_N == 0) begin
         if (lv[2]) up_ev = 1'b1;
         else       dn_ev = 1'b1;
      end
`endif
      case (m_state)
         0: begin
            nz = (m_min != 0) || m_sec;
            if (pr[1]) begin
               m_min = 0;
               m_sec = 1'b0;
            end else begin
               if (up_ev && !dn_ev)      m_min = (m_min + 1) % 100;
               else if (dn_ev && !up_ev) m_min = (m_min + 99) % 100;
               if (pr[4]) m_sec = !m_sec;
               if (pr[0] && nz) m_state = 1;
            end
         end
         1: begin
            if (pr[1])     m_state = 0;
            else if (zero) begin m_state = 3; m_t = 0; end
            else if (pr[0]) m_state = 2;
         end
         2: begin
            if (pr[1])      m_state = 0;
            else if (pr[0]) m_state = 1;
         end
         default: begin
            if (pr[1] || pr[0] || m_t == ALARM_N - 1) m_state = 0;
            else m_t++;
         end
      endcase
   endtask

   // ------------------------------------------------------------------ tests
   task automatic test_reset();
      rst = 1'b1;
      set_btns(B_UP);
      set_digits(1'b0);
      tick();
      tick();
      n_vec++;
      if (status !== S_IDLE) begin
         n_err++; $display("FAIL reset_status: got %b want %b", status, S_IDLE);
      end
      n_vec++;
      if (setpt !== 9'h005) begin
         n_err++; $display("FAIL reset_setpoint: got %h want %h", setpt, 9'h005);
      end
      rst = 1'b0;
      tick();
      n_vec++;
      if (setpt !== 9'h005) begin
         n_err++; $display("FAIL held_through_reset: got %h want %h", setpt, 9'h005);
      end
      set_btns(5'b0);
      tick();
   endtask

   task automatic test_edit();
      logic [4:0] seq_btn [11] = '{B_UP, B_UP, B_DOWN, B_UP | B_DOWN, B_HALF, B_HALF,
                                   B_CLEAR, B_DOWN, B_UP, B_DOWN, B_UP};
      int         seq_n   [11] = '{3, 9, 8, 1, 1, 1, 1, 1, 1, 1, 1};
      logic [8:0] seq_exp [11] = '{9'h008, 9'h017, 9'h009, 9'h009, 9'h109, 9'h009,
                                   9'h000, 9'h099, 9'h000, 9'h099, 9'h000};
      for (int i = 0; i < 11; i++) begin
         press(seq_btn[i], seq_n[i]);
         n_vec++;
         if (setpt !== seq_exp[i]) begin
            n_err++; $display("FAIL edit_step%0d: got %h want %h", i, setpt, seq_exp[i]);
         end
      end
      // One-cycle latency, and a held level steps only once.
      set_btns(B_UP);
      tick();
      n_vec++;
      if (setpt !== 9'h001) begin
         n_err++; $display("FAIL edit_latency: got %h want %h", setpt, 9'h001);
      end
      tick();
      n_vec++;
      if (setpt !== 9'h001) begin
         n_err++; $display("FAIL edit_held: got %h want %h", setpt, 9'h001);
      end
      set_btns(5'b0);
      tick();
   endtask

   task automatic test_start_gate();
      press(B_CLEAR);
      press(B_START);
      n_vec++;
      if (status !== S_IDLE) begin
         n_err++; $display("FAIL start_zero_ignored: got %b want %b", status, S_IDLE);
      end
      press(B_UP | B_START);
      n_vec++;
      if (status !== S_IDLE || setpt !== 9'h001) begin
         n_err++; $display("FAIL start_pre_edit: got %b/%h want %b/%h",
                           status, setpt, S_IDLE, 9'h001);
      end
      press(B_DOWN);
      press(B_HALF);
      n_vec++;
      if (setpt !== 9'h100) begin
         n_err++; $display("FAIL half_only: got %h want %h", setpt, 9'h100);
      end
      press(B_START);
      n_vec++;
      if (status !== S_RUN) begin
         n_err++; $display("FAIL start_half: got %b want %b", status, S_RUN);
      end
      press(B_CLEAR);
      n_vec++;
      if (status !== S_IDLE || setpt !== 9'h100) begin
         n_err++; $display("FAIL run_clear: got %b/%h want %b/%h",
                           status, setpt, S_IDLE, 9'h100);
      end
   endtask

   task automatic test_pause();
      press(B_START);
      press(B_UP);
      n_vec++;
      if (status !== S_RUN || setpt !== 9'h100) begin
         n_err++; $display("FAIL run_edit_ignored: got %b/%h want %b/%h",
                           status, setpt, S_RUN, 9'h100);
      end
      press(B_START);
      n_vec++;
      if (status !== S_PAUSE) begin
         n_err++; $display("FAIL pause: got %b want %b", status, S_PAUSE);
      end
      press(B_HALF);
      n_vec++;
      if (setpt !== 9'h100) begin
         n_err++; $display("FAIL pause_edit_ignored: got %h want %h", setpt, 9'h100);
      end
      press(B_START);
      n_vec++;
      if (status !== S_RUN) begin
         n_err++; $display("FAIL resume: got %b want %b", status, S_RUN);
      end
      press(B_START | B_CLEAR);
      n_vec++;
      if (status !== S_IDLE) begin
         n_err++; $display("FAIL clear_beats_start: got %b want %b", status, S_IDLE);
      end
   endtask

   task automatic test_alarm();
      logic [5:0] exp;
      press(B_START);
      set_digits(1'b1);
      tick();
      set_digits(1'b0);
      n_vec++;
      if (status !== S_ALARM1) begin
         n_err++; $display("FAIL alarm_entry: got %b want %b", status, S_ALARM1);
      end
      for (int t = 1; t < ALARM_N; t++) begin
         tick();
         exp = ((t / BEEP_N) % 2 == 0) ? S_ALARM1 : S_ALARM0;
         n_vec++;
         if (status !== exp) begin
            n_err++; $display("FAIL alarm_t%0d: got %b want %b", t, status, exp);
         end
      end
      tick();
      n_vec++;
      if (status !== S_IDLE || setpt !== 9'h100) begin
         n_err++; $display("FAIL alarm_timeout: got %b/%h want %b/%h",
                           status, setpt, S_IDLE, 9'h100);
      end
   endtask

   task automatic test_alarm_exit();
      logic [4:0] exit_btn [2] = '{B_CLEAR, B_START};
      for (int i = 0; i < 2; i++) begin
         press(B_START);
         set_digits(1'b1);
         tick();
         set_digits(1'b0);
         tick();
         tick();
         press(exit_btn[i]);
         n_vec++;
         if (status !== S_IDLE || setpt !== 9'h100) begin
            n_err++; $display("FAIL alarm_exit%0d: got %b/%h want %b/%h",
                              i, status, setpt, S_IDLE, 9'h100);
         end
      end
   endtask

   task automatic test_autorepeat();
      logic [8:0] exp;
`ifdef TIMER_CTRL_AUTOREPEAT_EN
      exp = 9'h004;
`else
      exp = 9'h001;
`endif
      press(B_CLEAR);
      set_btns(B_UP);
      repeat (HOLD_N + 2 * REP_N + 2) tick();
      set_btns(5'b0);
      tick();
      n_vec++;
      if (setpt !== exp) begin
         n_err++; $display("FAIL autorepeat: got %h want %h", setpt, exp);
      end
   endtask

   task automatic test_random();
      logic [4:0] lv;
      logic [5:0] exp_status;
      logic [8:0] exp_set;
      logic [1:0] ms;
      bit         zero;
      int         prob [5] = '{4, 12, 4, 4, 6};
      rst = 1'b1;
      set_btns(5'b0);
      set_digits(1'b0);
      tick();
      rst = 1'b0;
      model_reset();
      lv = 5'b0;
      for (int c = 0; c < 1500; c++) begin
         for (int b = 0; b < 5; b++)
            if ($urandom_range(prob[b] - 1) == 0) lv[b] = ~lv[b];
         zero = ($urandom_range(4) == 0);
         set_btns(lv);
         set_digits(zero);
         if (!zero) cnt_min_lo = 4'($urandom_range(9, 1));
         model_step(lv, zero);
         tick();
         ms         = 2'(m_state);
         exp_status = {ms, m_state != 0, m_state >= 2, m_state == 3,
                       m_state == 3 && ((m_t / BEEP_N) % 2 == 0)};
         exp_set    = {m_sec, 4'(m_min / 10), 4'(m_min % 10)};
         n_vec++;
         if (status !== exp_status || setpt !== exp_set) begin
            n_err++; $display("FAIL random_c%0d: got %b/%h want %b/%h",
                              c, status, setpt, exp_status, exp_set);
         end
      end
   endtask

   // --------------------------------------------------------------- sequence
   initial begin
      test_reset();
      test_edit();
      test_start_gate();
      test_pause();
      test_alarm();
      test_alarm_exit();
      test_autorepeat();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
